// File: rtl/fb_fill_ctrl_if.sv
// fb_fill_ctrl_if: CPU, config and frame-buffer port bundle for the fill engine.
// slave = engine side, master = CPU / frame-buffer side.
interface fb_fill_ctrl_if;
  logic        cpu_we;
  logic        cpu_re;
  logic [1:0]  cpu_mask;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        fb_we;
  logic        fb_re;
  logic [1:0]  fb_mask;
  logic [15:0] fb_addr;
  logic [31:0] fb_wdata;
  logic [31:0] fb_rdata;
  logic        done_pulse;

  modport slave (
    input  cpu_we, cpu_re, cpu_mask, cpu_addr, cpu_wdata,
    output cpu_rdata,
    input  cfg_we, cfg_addr, cfg_wdata,
    output cfg_rdata,
    output fb_we, fb_re, fb_mask, fb_addr, fb_wdata,
    input  fb_rdata,
    output done_pulse
  );

  modport master (
    output cpu_we, cpu_re, cpu_mask, cpu_addr, cpu_wdata,
    input  cpu_rdata,
    output cfg_we, cfg_addr, cfg_wdata,
    input  cfg_rdata,
    input  fb_we, fb_re, fb_mask, fb_addr, fb_wdata,
    output fb_rdata,
    input  done_pulse
  );
endinterface

// File: rtl/fb_fill_ctrl.sv
// fb_fill_ctrl: rectangle SET/XOR fill engine for the 640x480 1bpp frame buffer.
// The CPU always owns the port when it strobes; the engine uses idle cycles.
module fb_fill_ctrl #(
  parameter int unsigned ROW_WORDS = 20,
  parameter int unsigned MAX_ROW   = 479,
  parameter int unsigned MAX_WORD  = 19
) (
  input logic           clk,
  input logic           rst,
  fb_fill_ctrl_if.slave bus
);

  localparam logic [8:0]  LastRow  = 9'(MAX_ROW);
  localparam logic [4:0]  LastWord = 5'(MAX_WORD);
  localparam logic [13:0] RowStep  = 14'(ROW_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_RDWAIT,
    S_WB
  } state_t;

  state_t      state_q, state_d;
  logic        mode_q, mode_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        pulse_q, pulse_d;
  logic [8:0]  y0_q, y0_d;
  logic [8:0]  y1_q, y1_d;
  logic [4:0]  w0_q, w0_d;
  logic [4:0]  w1_q, w1_d;
  logic [31:0] pat_q, pat_d;
  logic [8:0]  row_q, row_d;
  logic [4:0]  col_q, col_d;
  logic [13:0] base_q, base_d;
  logic [31:0] wb_q, wb_d;

  logic        grant;
  logic        busy;
  logic        ctrl_wr;
  logic        start;
  logic        bad;
  logic        adv;
  logic        eng_we;
  logic        eng_re;
  logic [31:0] eng_wdata;
  logic [13:0] word;
  logic [13:0] start_base;

  assign grant   = !(bus.cpu_we || bus.cpu_re);
  assign busy    = (state_q != S_IDLE);
  assign ctrl_wr = bus.cfg_we && (bus.cfg_addr == 2'd0);
  assign start   = ctrl_wr && bus.cfg_wdata[0];
  assign bad     = (y0_q > y1_q) || (w0_q > w1_q) ||
                   (y1_q > LastRow) || (w1_q > LastWord);
  assign word    = base_q + 14'(col_q);

  // y0*ROW_WORDS as a constant shift-add sum
  always_comb begin
    start_base = '0;
    for (int i = 0; i < 5; i++) begin
      if (RowStep[i]) start_base = start_base + (14'(y0_q) << i);
    end
  end

  // config writes, start validation, fill FSM and word advance
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    done_d    = done_q;
    err_d     = err_q;
    pulse_d   = 1'b0;
    y0_d      = y0_q;
    y1_d      = y1_q;
    w0_d      = w0_q;
    w1_d      = w1_q;
    pat_d     = pat_q;
    row_d     = row_q;
    col_d     = col_q;
    base_d    = base_q;
    wb_d      = wb_q;
    adv       = 1'b0;
    eng_we    = 1'b0;
    eng_re    = 1'b0;
    eng_wdata = pat_q;

    if (bus.cfg_we && !busy) begin
      unique case (bus.cfg_addr)
        2'd1: begin
          y0_d = bus.cfg_wdata[8:0];
          y1_d = bus.cfg_wdata[24:16];
        end
        2'd2: begin
          w0_d = bus.cfg_wdata[4:0];
          w1_d = bus.cfg_wdata[12:8];
        end
        2'd3: pat_d = bus.cfg_wdata;
        default: ;
      endcase
    end

    if (ctrl_wr && bus.cfg_wdata[2]) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (bad) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            pulse_d = 1'b1;
          end else begin
            mode_d  = bus.cfg_wdata[1];
            row_d   = y0_q;
            col_d   = w0_q;
            base_d  = start_base;
            done_d  = 1'b0;
            err_d   = 1'b0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (grant) begin
          if (mode_q) begin
            eng_re  = 1'b1;
            state_d = S_RDWAIT;
          end else begin
            eng_we = 1'b1;
            adv    = 1'b1;
          end
        end
      end
      S_RDWAIT: begin
        wb_d    = bus.fb_rdata ^ pat_q;
        state_d = S_WB;
      end
      S_WB: begin
        if (grant) begin
          eng_we    = 1'b1;
          eng_wdata = wb_q;
          adv       = 1'b1;
          state_d   = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      if (col_q < w1_q) begin
        col_d = col_q + 5'd1;
      end else if (row_q < y1_q) begin
        col_d  = w0_q;
        row_d  = row_q + 9'd1;
        base_d = base_q + RowStep;
      end else begin
        done_d  = 1'b1;
        pulse_d = 1'b1;
        state_d = S_IDLE;
      end
    end
  end

  // state and register update
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pulse_q <= 1'b0;
      y0_q    <= '0;
      y1_q    <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
      pat_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      base_q  <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pulse_q <= pulse_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      pat_q   <= pat_d;
      row_q   <= row_d;
      col_q   <= col_d;
      base_q  <= base_d;
      wb_q    <= wb_d;
    end
  end

  // combinational config read-back
  always_comb begin
    bus.cfg_rdata = '0;
    unique case (bus.cfg_addr)
      2'd0: bus.cfg_rdata = {28'd0, err_q, done_q, mode_q, busy};
      2'd1: bus.cfg_rdata = {7'd0, y1_q, 7'd0, y0_q};
      2'd2: bus.cfg_rdata = {19'd0, w1_q, 3'd0, w0_q};
      2'd3: bus.cfg_rdata = pat_q;
      default: ;
    endcase
  end

  assign bus.fb_we      = grant ? eng_we : bus.cpu_we;
  assign bus.fb_re      = grant ? eng_re : bus.cpu_re;
  assign bus.fb_mask    = grant ? ((eng_we || eng_re) ? 2'b10 : 2'b00)
                                : bus.cpu_mask;
  assign bus.fb_addr    = grant ? {word, 2'b00} : bus.cpu_addr;
  assign bus.fb_wdata   = grant ? eng_wdata : bus.cpu_wdata;
  assign bus.cpu_rdata  = bus.fb_rdata;
  assign bus.done_pulse = pulse_q;

endmodule
